// File: rtl/sitcpxg_rx_stream_reader.sv
// SiTCP-XG receive-buffer consumer: holds the RX RAM, tracks the write pointer and
// drains bytes as a valid/ready word stream. Optional macro SITCPXG_RX_BYTECNT_EN enables RX_BYTE_CNT.
module sitcpxg_rx_stream_reader #(
    parameter int AW = 12
) (
    input  logic        XGMII_CLOCK,
    input  logic        RSTs,
    input  logic [15:0] USER_RX_WADR,
    input  logic [7:0]  USER_RX_WENB,
    input  logic [63:0] USER_RX_WDAT,
    output logic [15:0] USER_RX_RADR,
    output logic [15:0] USER_RX_SIZE,
    input  logic        USER_RX_CLR_ENB,
    output logic        USER_RX_CLR_REQ,
    input  logic        FLUSH,
    output logic [63:0] M_DATA,
    output logic [3:0]  M_BYTES,
    output logic        M_VALID,
    input  logic        M_READY,
    output logic [31:0] RX_BYTE_CNT
);

    localparam int PW = AW + 3;

    typedef enum logic [1:0] {IDLE, RD, OUT, CLR} state_t;

    state_t        state, state_nxt;
    logic [63:0]   mem [0:(1 << AW) - 1];
    logic [63:0]   rd_word;
    logic [63:0]   shifted;
    logic [63:0]   masked;
    logic [PW-1:0] wp, rp, avail, avail_q;
    logic [2:0]    low_lane;
    logic [2:0]    off;
    logic [3:0]    head_room;
    logic [3:0]    nbytes;
    logic [63:0]   m_data_q;
    logic [3:0]    m_bytes_q;
    logic          flush_q;
    logic          accept;
    logic          drained;
    logic          unused_wadr;

    assign unused_wadr  = ^USER_RX_WADR;
    assign avail        = wp - rp;
    assign drained      = (avail == '0);
    assign accept       = (state == OUT) && M_READY;
    assign USER_RX_RADR = 16'(rp);
    assign USER_RX_SIZE = 16'((1 << PW) - 16);
    assign M_DATA       = m_data_q;
    assign M_BYTES      = m_bytes_q;

    // Enabled bytes are contiguous, so the lowest set enable marks the last byte written.
    always_comb begin
        low_lane = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (USER_RX_WENB[i]) low_lane = 3'(i);
        end
    end

    always_ff @(posedge XGMII_CLOCK) begin
        for (int i = 0; i < 8; i++) begin
            if (USER_RX_WENB[i]) mem[USER_RX_WADR[PW-1:3]][8*i +: 8] <= USER_RX_WDAT[8*i +: 8];
        end
        rd_word <= mem[rp[PW-1:3]];
    end

    // Left-justify the word at rp and never run past the RAM word or past the written bytes.
    always_comb begin
        off       = rp[2:0];
        head_room = 4'd8 - {1'b0, off};
        nbytes    = (avail_q < PW'(head_room)) ? avail_q[3:0] : head_room;
        shifted   = rd_word << {off, 3'b000};
        masked    = shifted;
        for (int j = 0; j < 8; j++) begin
            if (4'(j) >= nbytes) masked[63 - 8*j -: 8] = 8'h00;
        end
    end

    always_ff @(posedge XGMII_CLOCK) begin
        if (RSTs) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        M_VALID         = 1'b0;
        USER_RX_CLR_REQ = 1'b0;
        case (state)
            IDLE: begin
                // An ended session with an empty buffer clears even without a FLUSH request.
                if (!drained)                                 state_nxt = RD;
                else if (USER_RX_CLR_ENB && (flush_q || drained)) state_nxt = CLR;
            end
            RD:  state_nxt = OUT;
            OUT: begin
                M_VALID = 1'b1;
                if (M_READY) state_nxt = IDLE;
            end
            CLR: begin
                USER_RX_CLR_REQ = 1'b1;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge XGMII_CLOCK) begin
        if (RSTs) begin
            wp        <= '0;
            rp        <= '0;
            avail_q   <= '0;
            m_data_q  <= '0;
            m_bytes_q <= '0;
            flush_q   <= 1'b0;
        end else begin
            if (state == CLR)           wp <= '0;
            else if (|USER_RX_WENB)     wp <= {USER_RX_WADR[PW-1:3], 3'b000} + PW'(4'd8 - {1'b0, low_lane});
            if (state == CLR)           rp <= '0;
            else if (accept)            rp <= rp + PW'(m_bytes_q);
            if (state == IDLE)          avail_q <= avail;
            if (state == RD) begin
                m_data_q  <= masked;
                m_bytes_q <= nbytes;
            end
            if (state == CLR)           flush_q <= 1'b0;
            else if (FLUSH)             flush_q <= 1'b1;
        end
    end

`ifdef SITCPXG_RX_BYTECNT_EN
    logic [31:0] byte_cnt;

    always_ff @(posedge XGMII_CLOCK) begin
        if (RSTs || state == CLR) byte_cnt <= 32'd0;
        else if (accept)          byte_cnt <= byte_cnt + 32'(m_bytes_q);
    end

    assign RX_BYTE_CNT = byte_cnt;
`else
    assign RX_BYTE_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_sitcpxg_rx_stream_reader.sv
// Directed bench for sitcpxg_rx_stream_reader (AW=9) with hand-computed expectations.
module tb_sitcpxg_rx_stream_reader;

    logic        clk;
    logic        rst;
    logic [15:0] wadr;
    logic [7:0]  wenb;
    logic [63:0] wdat;
    logic [15:0] radr;
    logic [15:0] rx_size;
    logic        clr_enb;
    logic        clr_req;
    logic        flush;
    logic [63:0] m_data;
    logic [3:0]  m_bytes;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] byte_cnt;

    int tests_run = 0;
    int failures  = 0;

    sitcpxg_rx_stream_reader #(.AW(9)) dut (
        .XGMII_CLOCK     (clk),
        .RSTs            (rst),
        .USER_RX_WADR    (wadr),
        .USER_RX_WENB    (wenb),
        .USER_RX_WDAT    (wdat),
        .USER_RX_RADR    (radr),
        .USER_RX_SIZE    (rx_size),
        .USER_RX_CLR_ENB (clr_enb),
        .USER_RX_CLR_REQ (clr_req),
        .FLUSH           (flush),
        .M_DATA          (m_data),
        .M_BYTES         (m_bytes),
        .M_VALID         (m_valid),
        .M_READY         (m_ready),
        .RX_BYTE_CNT     (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // One write cycle, driven after a falling edge and released after the next one.
    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] e, input logic [63:0] d);
        wadr = a;
        wenb = e;
        wdat = d;
        @(negedge clk);
        wenb = 8'h00;
    endtask

    task automatic waitValid(input string tag, output int cycles);
        cycles = 0;
        while (!m_valid && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, 64'(m_valid), 64'd1);
    endtask

    task automatic acceptWord();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    int          cyc;
    int          nwords;
    int          words_at_clr;
    logic        clr_seen;
    logic [63:0] got_data [2];
    logic [3:0]  got_bytes [2];
    logic [31:0] cnt_expect;

    initial begin
        rst     = 1'b1;
        wadr    = 16'h0;
        wenb    = 8'h0;
        wdat    = 64'h0;
        clr_enb = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_radr",    64'(radr),     64'h0);
        checkOutput("rst_valid",   64'(m_valid),  64'h0);
        checkOutput("rst_data",    m_data,        64'h0);
        checkOutput("rst_bytes",   64'(m_bytes),  64'h0);
        checkOutput("rst_clr_req", 64'(clr_req),  64'h0);
        checkOutput("rst_cnt",     64'(byte_cnt), 64'h0);
        checkOutput("rx_size",     64'(rx_size),  64'h0FF0);
        rst = 1'b0;
        @(negedge clk);

        // Aligned full word
        applyStimulus(16'h0000, 8'hFF, 64'h0011223344556677);
        waitValid("s1_valid", cyc);
        checkOutput("s1_latency", 64'(cyc + 1), 64'd3);
        checkOutput("s1_data",  m_data,       64'h0011223344556677);
        checkOutput("s1_bytes", 64'(m_bytes), 64'd8);
        acceptWord();
        checkOutput("s1_radr",  64'(radr),    64'h0008);
        checkOutput("s1_valid_drop", 64'(m_valid), 64'h0);

        // Partial word, then the rest of the same RAM word from an unaligned rp
        applyStimulus(16'h0008, 8'hE0, 64'hAABBCCDDEEFF0011);
        waitValid("s2a_valid", cyc);
        checkOutput("s2a_data",  m_data,       64'hAABBCC0000000000);
        checkOutput("s2a_bytes", 64'(m_bytes), 64'd3);
        acceptWord();
        checkOutput("s2a_radr",  64'(radr),    64'h000B);
        applyStimulus(16'h0008, 8'h1F, 64'h1122334455667788);
        waitValid("s2b_valid", cyc);
        checkOutput("s2b_data",  m_data,       64'h4455667788000000);
        checkOutput("s2b_bytes", 64'(m_bytes), 64'd5);
        acceptWord();
        checkOutput("s2b_radr",  64'(radr),    64'h0010);
`ifdef SITCPXG_RX_BYTECNT_EN
        cnt_expect = 32'd16;
`else
        cnt_expect = 32'd0;
`endif
        checkOutput("s2_cnt", 64'(byte_cnt), 64'(cnt_expect));

        // Backpressure: word must hold steady while M_READY is low
        applyStimulus(16'h0010, 8'hFF, 64'h0102030405060708);
        waitValid("bp_valid", cyc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", 64'(m_valid), 64'h1);
            checkOutput("bp_hold_data",  m_data,       64'h0102030405060708);
            checkOutput("bp_hold_radr",  64'(radr),    64'h0010);
        end
        acceptWord();
        checkOutput("bp_radr",  64'(radr),    64'h0018);
        checkOutput("bp_valid", 64'(m_valid), 64'h0);

        // Clear with 16 bytes pending: both words first, then a single clear request
        wadr = 16'h0018; wenb = 8'hFF; wdat = 64'hC0C1C2C3C4C5C6C7;
        @(negedge clk);
        wadr = 16'h0020; wenb = 8'hFF; wdat = 64'hD0D1D2D3D4D5D6D7;
        @(negedge clk);
        wenb    = 8'h00;
        flush   = 1'b1;
        clr_enb = 1'b1;
        m_ready = 1'b1;
        nwords       = 0;
        words_at_clr = -1;
        clr_seen     = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            flush = 1'b0;
            if (clr_req) begin
                clr_seen     = 1'b1;
                words_at_clr = nwords;
                clr_enb      = 1'b0;
                break;
            end
            if (m_valid && m_ready) begin
                if (nwords < 2) begin
                    got_data[nwords]  = m_data;
                    got_bytes[nwords] = m_bytes;
                end
                nwords++;
            end
        end
        checkOutput("clr_seen",     64'(clr_seen),     64'h1);
        checkOutput("clr_words",    64'(words_at_clr), 64'd2);
        checkOutput("clr_w0_data",  got_data[0],       64'hC0C1C2C3C4C5C6C7);
        checkOutput("clr_w0_bytes", 64'(got_bytes[0]), 64'd8);
        checkOutput("clr_w1_data",  got_data[1],       64'hD0D1D2D3D4D5D6D7);
        checkOutput("clr_w1_bytes", 64'(got_bytes[1]), 64'd8);
        clr_enb = 1'b0;
        @(negedge clk);
        m_ready = 1'b0;
        checkOutput("clr_one_cycle", 64'(clr_req),  64'h0);
        checkOutput("clr_radr",      64'(radr),     64'h0);
        checkOutput("clr_cnt",       64'(byte_cnt), 64'h0);
        repeat (3) @(negedge clk);
        checkOutput("clr_idle_valid", 64'(m_valid), 64'h0);

        // Wrap: walk rp to 0x0FFC, then deliver 8 bytes straddling the end of memory
        m_ready = 1'b1;
        applyStimulus(16'h0FF8, 8'hF0, 64'h0);
        for (int i = 0; i < 3000 && radr != 16'h0FFC; i++) @(negedge clk);
        m_ready = 1'b0;
        checkOutput("wrap_pre_radr", 64'(radr), 64'h0FFC);
        @(negedge clk);
        checkOutput("wrap_pre_valid", 64'(m_valid), 64'h0);
        wadr = 16'h0FF8; wenb = 8'h0F; wdat = 64'hDEADBEEFA1A2A3A4;
        @(negedge clk);
        applyStimulus(16'h0000, 8'hF0, 64'hB1B2B3B455667788);
        waitValid("wrap_w0_valid", cyc);
        checkOutput("wrap_w0_data",  m_data,       64'hA1A2A3A400000000);
        checkOutput("wrap_w0_bytes", 64'(m_bytes), 64'd4);
        acceptWord();
        checkOutput("wrap_w0_radr",  64'(radr),    64'h0000);
        waitValid("wrap_w1_valid", cyc);
        checkOutput("wrap_w1_data",  m_data,       64'hB1B2B3B400000000);
        checkOutput("wrap_w1_bytes", 64'(m_bytes), 64'd4);
        acceptWord();
        checkOutput("wrap_w1_radr",  64'(radr),    64'h0004);

        // Reset while a word is pending drops it
        applyStimulus(16'h0008, 8'hFF, 64'h8877665544332211);
        waitValid("rst_out_valid", cyc);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_out_drop",  64'(m_valid),  64'h0);
        checkOutput("rst_out_data",  m_data,        64'h0);
        checkOutput("rst_out_radr",  64'(radr),     64'h0);
        checkOutput("rst_out_cnt",   64'(byte_cnt), 64'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_out_quiet", 64'(m_valid),  64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
